online_stimulus_sequencer: RTL

// - Sequences random high-radix operand pairs from two LFSR digit-vector generators into an online (MSD-first) arithmetic unit.
// - Per vector: latch both parallel words, stream digits MSD-first over a valid/ready handshake, then append ONLINE_DELAY zero digits to drain the result.
// - Publishes the latched operands for the golden-model checker and counts completed vectors.
// - Sits between the LFSR digit-vector generators and the online operator under test.

---
 rtl/online_stimulus_sequencer_if.sv | 30 +++
 rtl/online_stimulus_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/online_stimulus_sequencer_if.sv
// Digit-serial handshake between the stimulus sequencer and the online operator.
// The sequencer drives the digit pair and framing; the operator returns ready.
interface online_stimulus_sequencer_if #(
    parameter int radix_bits = 3
);
    logic [radix_bits-1:0] dig_a;
    logic [radix_bits-1:0] dig_b;
    logic                  dig_valid;
    logic                  dig_first;
    logic                  dig_last;
    logic                  dut_ready;

    modport master (
        output dig_a,
        output dig_b,
        output dig_valid,
        output dig_first,
        output dig_last,
        input  dut_ready
    );

    modport slave (
        input  dig_a,
        input  dig_b,
        input  dig_valid,
        input  dig_first,
        input  dig_last,
        output dut_ready
    );
endinterface

// File: rtl/online_stimulus_sequencer.sv
// Latches LFSR operand pairs and streams them MSD-first into an online unit,
// appending ONLINE_DELAY zero digits per vector so the result can drain.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | latch operand words, preset digit index to the MSD
// STREAM | present operand digit[index], step on each accept
// FLUSH  | present zero digits until the flush counter expires
// FIN    | one-cycle done pulse, then back to IDLE
module online_stimulus_sequencer #(
    parameter int no_of_digits = 8,
    parameter int radix_bits   = 3,
    parameter int ONLINE_DELAY = 3,
    parameter int CNT_BITS     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [CNT_BITS-1:0]                num_vectors,
    input  logic [no_of_digits*radix_bits-1:0] lfsr_word_a,
    input  logic [no_of_digits*radix_bits-1:0] lfsr_word_b,
    online_stimulus_sequencer_if.master        dig,
    output logic [no_of_digits*radix_bits-1:0] op_a,
    output logic [no_of_digits*radix_bits-1:0] op_b,
    output logic                               op_valid,
    output logic [CNT_BITS-1:0]                vec_count,
    output logic                               busy,
    output logic                               done
);
    localparam int WORD_W = no_of_digits * radix_bits;
    localparam int IDX_W  = (no_of_digits > 1) ? $clog2(no_of_digits) : 1;
    localparam int FL_W   = (ONLINE_DELAY > 1) ? $clog2(ONLINE_DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_FLUSH,
        S_FIN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    dig_idx;
    logic [FL_W-1:0]     flush_cnt;
    logic [CNT_BITS-1:0] num_q;
    logic [CNT_BITS-1:0] vec_next;
    logic [WORD_W-1:0]   shift_a;
    logic [WORD_W-1:0]   shift_b;
    logic                valid_c;
    logic                accept;

    assign vec_next = vec_count + CNT_BITS'(1);
    assign accept   = valid_c && dig.dut_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        valid_c       = 1'b0;
        shift_a       = '0;
        shift_b       = '0;
        dig.dig_a     = '0;
        dig.dig_b     = '0;
        dig.dig_first = 1'b0;
        dig.dig_last  = 1'b0;
        busy          = (state != S_IDLE);
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_vectors != '0) ? S_LOAD : S_FIN;
                end
            end
            S_LOAD: begin
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                valid_c       = 1'b1;
                shift_a       = op_a >> (radix_bits * int'(dig_idx));
                shift_b       = op_b >> (radix_bits * int'(dig_idx));
                dig.dig_a     = shift_a[radix_bits-1:0];
                dig.dig_b     = shift_b[radix_bits-1:0];
                dig.dig_first = (dig_idx == IDX_W'(no_of_digits - 1));
                if (accept && dig_idx == '0) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                valid_c      = 1'b1;
                dig.dig_last = (flush_cnt == '0);
                if (accept && flush_cnt == '0) begin
                    state_nxt = (vec_next == num_q) ? S_FIN : S_LOAD;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        dig.dig_valid = valid_c;
    end

    // Datapath: operands, digit index, flush counter and run bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            op_valid  <= 1'b0;
            vec_count <= '0;
            num_q     <= '0;
            dig_idx   <= '0;
            flush_cnt <= '0;
        end else begin
            op_valid <= (state == S_LOAD);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_q     <= num_vectors;
                        vec_count <= '0;
                    end
                end
                S_LOAD: begin
                    op_a    <= lfsr_word_a;
                    op_b    <= lfsr_word_b;
                    dig_idx <= IDX_W'(no_of_digits - 1);
                end
                S_STREAM: begin
                    if (accept) begin
                        if (dig_idx == '0) begin
                            flush_cnt <= FL_W'(ONLINE_DELAY - 1);
                        end else begin
                            dig_idx <= dig_idx - IDX_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (accept) begin
                        if (flush_cnt == '0) begin
                            vec_count <= vec_next;
                        end else begin
                            flush_cnt <= flush_cnt - FL_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
